// File: rtl/bus_pkg.sv
// Shared types and constants for the Harvard-to-Avalon bus adapter.
package bus_pkg;

    // Adapter sequencing states; DECIDE is the one-cycle substate of FETCH
    // that gives the CPU a cycle to decode the freshly captured instruction.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECIDE = 3'd2,
        DATA   = 3'd3,
        EXEC   = 3'd4,
        HALT   = 3'd5
    } adapter_state_t;

    // Every bus access is a full 32-bit word.
    localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;

endpackage

// File: rtl/harvard_bus_adapter.sv
// Serialises the Harvard CPU's instruction and data ports onto a single
// Avalon-style bus: fetch, optional data access, then one execute strobe.
//
// Bus handshake: a transfer is offered while read or write is high and
// completes on the first clock edge where waitrequest is low. Until then
// address, read, write and writedata stay unchanged, because they are derived
// from the state and the CPU ports, and the CPU only moves on clock_enable.
module harvard_bus_adapter
    import bus_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    input  logic [31:0] cpu_instr_address,
    output logic [31:0] cpu_instr_readdata,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    output logic [31:0] cpu_data_readdata,
    output logic        cpu_clock_enable,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    adapter_state_t state;
    adapter_state_t next_state;
    logic [31:0]    instr_buf;
    logic [31:0]    data_buf;

    // The fetch address always comes from the CPU; the reset vector is only
    // documentation here. Byte offsets are dropped for word addressing.
    logic unused_bits;
    assign unused_bits = ^{RESET_VECTOR, cpu_instr_address[1:0], cpu_data_address[1:0]};

    assign byteenable         = BYTEENABLE_ALL;
    assign cpu_instr_readdata = instr_buf;
    assign cpu_data_readdata  = data_buf;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture returned words on the edge that completes each read.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_buf <= 32'd0;
            data_buf  <= 32'd0;
        end else begin
            if (state == FETCH && !waitrequest) begin
                instr_buf <= readdata;
            end
            if (state == DATA && cpu_data_read && !waitrequest) begin
                data_buf <= readdata;
            end
        end
    end

    // Next-state and bus/CPU strobes; read wins when both data requests are set.
    always_comb begin
        next_state       = state;
        read             = 1'b0;
        write            = 1'b0;
        address          = 32'd0;
        writedata        = 32'd0;
        cpu_clock_enable = 1'b0;
        case (state)
            IDLE: begin
                cpu_clock_enable = 1'b1;
                next_state       = FETCH;
            end
            FETCH: begin
                read    = 1'b1;
                address = {cpu_instr_address[31:2], 2'b00};
                if (!waitrequest) begin
                    next_state = DECIDE;
                end
            end
            DECIDE: begin
                if (cpu_data_read || cpu_data_write) begin
                    next_state = DATA;
                end else begin
                    next_state = EXEC;
                end
            end
            DATA: begin
                address = {cpu_data_address[31:2], 2'b00};
                if (cpu_data_read) begin
                    read = 1'b1;
                end else if (cpu_data_write) begin
                    write     = 1'b1;
                    writedata = cpu_data_writedata;
                end
                if (!waitrequest) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                cpu_clock_enable = 1'b1;
                next_state       = cpu_active ? FETCH : HALT;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_harvard_bus_adapter.sv
// Directed bench for harvard_bus_adapter: the bench plays both the CPU and
// the bus memory, stepping cycle by cycle with hand-computed expectations.
module tb_harvard_bus_adapter;
    import bus_pkg::*;

    logic        clk;
    logic        reset;
    logic        cpu_active;
    logic [31:0] cpu_instr_address;
    logic [31:0] cpu_instr_readdata;
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [31:0] cpu_data_writedata;
    logic [31:0] cpu_data_readdata;
    logic        cpu_clock_enable;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    int asserts;
    int fails;

    harvard_bus_adapter #(.RESET_VECTOR(32'hBFC00000)) dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_active         (cpu_active),
        .cpu_instr_address  (cpu_instr_address),
        .cpu_instr_readdata (cpu_instr_readdata),
        .cpu_data_address   (cpu_data_address),
        .cpu_data_read      (cpu_data_read),
        .cpu_data_write     (cpu_data_write),
        .cpu_data_writedata (cpu_data_writedata),
        .cpu_data_readdata  (cpu_data_readdata),
        .cpu_clock_enable   (cpu_clock_enable),
        .address            (address),
        .read               (read),
        .write              (write),
        .writedata          (writedata),
        .byteenable         (byteenable),
        .waitrequest        (waitrequest),
        .readdata           (readdata)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_active = 1'b1; cpu_instr_address = 32'hBFC00000;
        cpu_data_address = 32'd0; cpu_data_read = 1'b0; cpu_data_write = 1'b0;
        cpu_data_writedata = 32'd0; waitrequest = 1'b0; readdata = 32'd0;
        tick();
        tick();
        asserts++; if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
        asserts++; if (read !== 1'b0) begin fails++; $display("FAIL reset_read: got %b want 0", read); end
        asserts++; if (write !== 1'b0) begin fails++; $display("FAIL reset_write: got %b want 0", write); end
        asserts++; if (address !== 32'd0) begin fails++; $display("FAIL reset_address: got %h want 0", address); end
        asserts++; if (writedata !== 32'd0) begin fails++; $display("FAIL reset_writedata: got %h want 0", writedata); end
        asserts++; if (byteenable !== 4'b1111) begin fails++; $display("FAIL reset_byteenable: got %b want 1111", byteenable); end
        asserts++; if (cpu_instr_readdata !== 32'd0) begin fails++; $display("FAIL reset_instr_buf: got %h want 0", cpu_instr_readdata); end
        asserts++; if (cpu_data_readdata !== 32'd0) begin fails++; $display("FAIL reset_data_buf: got %h want 0", cpu_data_readdata); end
        asserts++; if (cpu_clock_enable !== 1'b1) begin fails++; $display("FAIL reset_clock_enable: got %b want 1", cpu_clock_enable); end
    endtask

    // NOP at the reset vector: FETCH, DECIDE, EXEC.
    task automatic test_nop_fetch();
        reset = 1'b0; readdata = 32'h00000000;
        tick();
        asserts++; if (read !== 1'b1) begin fails++; $display("FAIL nop_read: got %b want 1", read); end
        asserts++; if (address !== 32'hBFC00000) begin fails++; $display("FAIL nop_address: got %h want bfc00000", address); end
        asserts++; if (cpu_clock_enable !== 1'b0) begin fails++; $display("FAIL nop_fetch_ce: got %b want 0", cpu_clock_enable); end
        tick();
        asserts++; if (read !== 1'b0 || write !== 1'b0) begin fails++; $display("FAIL nop_decide_strobes: got r%b w%b want r0 w0", read, write); end
        asserts++; if (cpu_clock_enable !== 1'b0) begin fails++; $display("FAIL nop_decide_ce: got %b want 0", cpu_clock_enable); end
        tick();
        asserts++; if (cpu_clock_enable !== 1'b1) begin fails++; $display("FAIL nop_exec_ce: got %b want 1", cpu_clock_enable); end
        cpu_instr_address = 32'hBFC00004;
        tick();
    endtask

    // LW: unaligned data address is word-aligned; loaded word buffered.
    task automatic test_lw();
        readdata = 32'h8C010002;
        asserts++; if (address !== 32'hBFC00004) begin fails++; $display("FAIL lw_fetch_address: got %h want bfc00004", address); end
        tick();
        asserts++; if (cpu_instr_readdata !== 32'h8C010002) begin fails++; $display("FAIL lw_instr_buf: got %h want 8c010002", cpu_instr_readdata); end
        cpu_data_read = 1'b1; cpu_data_address = 32'h00001002;
        tick();
        asserts++; if (read !== 1'b1 || write !== 1'b0) begin fails++; $display("FAIL lw_data_strobes: got r%b w%b want r1 w0", read, write); end
        asserts++; if (address !== 32'h00001000) begin fails++; $display("FAIL lw_data_address: got %h want 00001000", address); end
        asserts++; if (cpu_clock_enable !== 1'b0) begin fails++; $display("FAIL lw_data_ce: got %b want 0", cpu_clock_enable); end
        readdata = 32'hDEADBEEF;
        tick();
        asserts++; if (cpu_data_readdata !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data_buf: got %h want deadbeef", cpu_data_readdata); end
        asserts++; if (cpu_clock_enable !== 1'b1) begin fails++; $display("FAIL lw_exec_ce: got %b want 1", cpu_clock_enable); end
        cpu_data_read = 1'b0; cpu_instr_address = 32'hBFC00008;
        tick();
    endtask

    // SW with three wait cycles: strobes and data held for four cycles.
    task automatic test_sw_wait();
        readdata = 32'hAC020000;
        tick();
        cpu_data_write = 1'b1; cpu_data_address = 32'h00002000; cpu_data_writedata = 32'h12345678;
        waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            waitrequest = (i < 3);
            asserts++; if (write !== 1'b1 || read !== 1'b0) begin fails++; $display("FAIL sw_strobes_%0d: got r%b w%b want r0 w1", i, read, write); end
            asserts++; if (address !== 32'h00002000) begin fails++; $display("FAIL sw_address_%0d: got %h want 00002000", i, address); end
            asserts++; if (writedata !== 32'h12345678) begin fails++; $display("FAIL sw_writedata_%0d: got %h want 12345678", i, writedata); end
            asserts++; if (cpu_clock_enable !== 1'b0) begin fails++; $display("FAIL sw_ce_%0d: got %b want 0", i, cpu_clock_enable); end
            tick();
        end
        asserts++; if (cpu_clock_enable !== 1'b1 || write !== 1'b0) begin fails++; $display("FAIL sw_exec: got ce%b w%b want ce1 w0", cpu_clock_enable, write); end
        asserts++; if (cpu_data_readdata !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_data_buf_hold: got %h want deadbeef", cpu_data_readdata); end
        cpu_data_write = 1'b0; cpu_instr_address = 32'hBFC0000C;
        tick();
        asserts++; if (cpu_clock_enable !== 1'b0) begin fails++; $display("FAIL sw_single_pulse: got %b want 0", cpu_clock_enable); end
    endtask

    // Read and write requested together: only the read goes out.
    task automatic test_both_requests();
        readdata = 32'h11112222;
        tick();
        cpu_data_read = 1'b1; cpu_data_write = 1'b1;
        cpu_data_address = 32'h00003004; cpu_data_writedata = 32'hCAFEF00D;
        tick();
        asserts++; if (read !== 1'b1 || write !== 1'b0) begin fails++; $display("FAIL both_strobes: got r%b w%b want r1 w0", read, write); end
        asserts++; if (address !== 32'h00003004) begin fails++; $display("FAIL both_address: got %h want 00003004", address); end
        readdata = 32'h55AA55AA;
        tick();
        asserts++; if (cpu_data_readdata !== 32'h55AA55AA) begin fails++; $display("FAIL both_data_buf: got %h want 55aa55aa", cpu_data_readdata); end
        asserts++; if (cpu_instr_readdata !== 32'h11112222) begin fails++; $display("FAIL both_instr_buf: got %h want 11112222", cpu_instr_readdata); end
        cpu_data_read = 1'b0; cpu_data_write = 1'b0; cpu_instr_address = 32'hBFC00100;
        tick();
    endtask

    // 200 instructions with random waitrequest; instruction fetches live at
    // 0xBFC0xxxx and data at 0x0000xxxx so the bench can tell them apart.
    task automatic test_random_wait();
        int          pulses;
        int          fetches;
        int          cycles;
        int          overlap;
        int          kind;
        logic [31:0] exp_instr;
        logic [31:0] exp_data;
        logic [31:0] pc;
        pulses = 0; fetches = 0; cycles = 0; overlap = 0;
        exp_instr = cpu_instr_readdata_model_init();
        exp_data = 32'h55AA55AA;
        pc = 32'hBFC00100;
        while (pulses < 200 && cycles < 6000) begin
            waitrequest = 1'($urandom_range(0, 1));
            readdata = $urandom;
            #1;
            if (read && write) overlap++;
            if (cpu_clock_enable) begin
                pulses++;
                asserts++; if (fetches !== pulses) begin fails++; $display("FAIL rnd_fetch_count: got %0d fetches want %0d", fetches, pulses); end
                asserts++; if (cpu_instr_readdata !== exp_instr) begin fails++; $display("FAIL rnd_instr_buf: got %h want %h", cpu_instr_readdata, exp_instr); end
                asserts++; if (cpu_data_readdata !== exp_data) begin fails++; $display("FAIL rnd_data_buf: got %h want %h", cpu_data_readdata, exp_data); end
                pc = pc + 32'd4;
                kind = $urandom_range(0, 2);
                cpu_instr_address = pc;
                cpu_data_read = (kind == 1);
                cpu_data_write = (kind == 2);
                cpu_data_address = 32'h00004000 + 32'($urandom_range(0, 255));
                cpu_data_writedata = $urandom;
            end
            if (read && !waitrequest) begin
                if (address[31]) begin
                    fetches++;
                    exp_instr = readdata;
                end else begin
                    exp_data = readdata;
                end
            end
            tick();
            cycles++;
        end
        asserts++; if (pulses !== 200) begin fails++; $display("FAIL rnd_budget: got %0d pulses want 200", pulses); end
        asserts++; if (overlap !== 0) begin fails++; $display("FAIL rnd_read_write_overlap: got %0d cycles want 0", overlap); end
        cpu_data_read = 1'b0; cpu_data_write = 1'b0;
    endtask

    // Instruction buffer content when the random test starts (last fetch above).
    function automatic logic [31:0] cpu_instr_readdata_model_init();
        return 32'h11112222;
    endfunction

    // Reset in the middle of a stalled data write abandons it.
    task automatic test_reset_mid_data();
        waitrequest = 1'b0; readdata = 32'hAC030000;
        cpu_data_write = 1'b1; cpu_data_address = 32'h00005000; cpu_data_writedata = 32'hA5A5A5A5;
        tick();
        waitrequest = 1'b1;
        tick();
        asserts++; if (write !== 1'b1) begin fails++; $display("FAIL midrst_pre_write: got %b want 1", write); end
        reset = 1'b1;
        tick();
        asserts++; if (read !== 1'b0 || write !== 1'b0) begin fails++; $display("FAIL midrst_strobes: got r%b w%b want r0 w0", read, write); end
        asserts++; if (dut.state !== IDLE) begin fails++; $display("FAIL midrst_state: got %0d want %0d", dut.state, IDLE); end
        asserts++; if (cpu_instr_readdata !== 32'd0) begin fails++; $display("FAIL midrst_instr_buf: got %h want 0", cpu_instr_readdata); end
        cpu_data_write = 1'b0; waitrequest = 1'b0;
    endtask

    // cpu_active low during EXEC: halt, no bus traffic afterwards.
    task automatic test_halt();
        int busy;
        busy = 0;
        reset = 1'b0; cpu_instr_address = 32'hBFC00000; readdata = 32'h00000000;
        tick();
        tick();
        tick();
        asserts++; if (cpu_clock_enable !== 1'b1) begin fails++; $display("FAIL halt_exec_ce: got %b want 1", cpu_clock_enable); end
        cpu_active = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (read || write || cpu_clock_enable) busy++;
            tick();
        end
        asserts++; if (busy !== 0) begin fails++; $display("FAIL halt_quiet: got %0d active cycles want 0", busy); end
        asserts++; if (dut.state !== HALT) begin fails++; $display("FAIL halt_state: got %0d want %0d", dut.state, HALT); end
    endtask

    initial begin
        asserts = 0;
        fails = 0;
        test_reset();
        test_nop_fetch();
        test_lw();
        test_sw_wait();
        test_both_requests();
        test_random_wait();
        test_reset_mid_data();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
